// File: rtl/axi_lite_beat_master_pkg.sv
// -----------------------------------------------------------------------------
// axi_lite_beat_master_pkg
//
// Shared definitions for the single-beat AXI4-Lite master that sits behind the
// cache data-transfer stage:
//   - beat_state_e      : beat FSM state encoding
//   - AXI_RESP_*        : AXI response encodings
//   - AXI_PROT_DEFAULT  : protection attribute driven on awprot/arprot
//   - resp_is_error()   : classifies a handshaked response as an error
// -----------------------------------------------------------------------------
package axi_lite_beat_master_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4,
      ST_DONE    = 3'd5
   } beat_state_e;

   localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
   localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
   localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

   // Unprivileged, secure, data access.
   localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

   // Anything other than OKAY (SLVERR, DECERR, or an unexpected EXOKAY on a
   // non-exclusive access) is reported as an error.
   function automatic logic resp_is_error(input logic [1:0] resp);
      return (resp != AXI_RESP_OKAY);
   endfunction

endpackage : axi_lite_beat_master_pkg

// File: rtl/axi_lite_beat_master.sv
// -----------------------------------------------------------------------------
// axi_lite_beat_master
//
// Single-beat AXI4-Lite master. While start_write_i or start_read_i is held
// high it performs one AXI4-Lite write or read per beat using the operands
// presented on addr_i / data_i when the FSM leaves IDLE, and pulses done_o for
// one cycle at the end of every beat so the upstream stage can advance its
// address counter and shift register. Write has priority over read.
//
// Optional feature (macro MAVERIC_AXI_RESP_ERR_EN):
//   defined   : error_o is a sticky flag set by any handshaked non-OKAY
//               bresp_i / rresp_i, cleared in any cycle where both start
//               inputs are low (clear wins over set).
//   undefined : error_o is tied low and the response inputs are ignored.
//
// Ports:
//   clk_i, arst_i          clock, asynchronous active-high reset
//   start_read_i/_write_i  level requests; beats repeat while held
//   addr_i, data_i         beat address / write word
//   done_o                 one-cycle pulse per completed beat
//   data_o                 last read word (held across write beats)
//   error_o                sticky response error (see above)
//   aw*/w*/b*              AXI4-Lite write address, write data, write response
//   ar*/r*                 AXI4-Lite read address, read data
// -----------------------------------------------------------------------------
module axi_lite_beat_master
   import axi_lite_beat_master_pkg::*;
#(
   parameter int AXI_ADDR_WIDTH = 64,
   parameter int AXI_DATA_WIDTH = 32
) (
   input  logic                        clk_i,
   input  logic                        arst_i,

   input  logic                        start_read_i,
   input  logic                        start_write_i,
   input  logic [AXI_ADDR_WIDTH-1:0]   addr_i,
   input  logic [AXI_DATA_WIDTH-1:0]   data_i,
   output logic                        done_o,
   output logic [AXI_DATA_WIDTH-1:0]   data_o,
   output logic                        error_o,

   output logic [AXI_ADDR_WIDTH-1:0]   awaddr_o,
   output logic [2:0]                  awprot_o,
   output logic                        awvalid_o,
   input  logic                        awready_i,
   output logic [AXI_DATA_WIDTH-1:0]   wdata_o,
   output logic [AXI_DATA_WIDTH/8-1:0] wstrb_o,
   output logic                        wvalid_o,
   input  logic                        wready_i,
   input  logic [1:0]                  bresp_i,
   input  logic                        bvalid_i,
   output logic                        bready_o,

   output logic [AXI_ADDR_WIDTH-1:0]   araddr_o,
   output logic [2:0]                  arprot_o,
   output logic                        arvalid_o,
   input  logic                        arready_i,
   input  logic [AXI_DATA_WIDTH-1:0]   rdata_i,
   input  logic [1:0]                  rresp_i,
   input  logic                        rvalid_i,
   output logic                        rready_o
);

   beat_state_e                state_q,   state_d;
   logic                       awvalid_q, awvalid_d;
   logic                       wvalid_q,  wvalid_d;
   logic                       aw_acc_q,  aw_acc_d;
   logic                       w_acc_q,   w_acc_d;
   logic                       bready_q,  bready_d;
   logic                       arvalid_q, arvalid_d;
   logic                       rready_q,  rready_d;
   logic [AXI_ADDR_WIDTH-1:0]  awaddr_q,  awaddr_d;
   logic [AXI_ADDR_WIDTH-1:0]  araddr_q,  araddr_d;
   logic [AXI_DATA_WIDTH-1:0]  wdata_q,   wdata_d;
   logic [AXI_DATA_WIDTH-1:0]  rdata_q,   rdata_d;

   logic aw_hs, w_hs, b_hs, ar_hs, r_hs;
   logic aw_done, w_done;

   assign aw_hs = awvalid_q & awready_i;
   assign w_hs  = wvalid_q  & wready_i;
   assign b_hs  = bvalid_i  & bready_q;
   assign ar_hs = arvalid_q & arready_i;
   assign r_hs  = rvalid_i  & rready_q;

   // AW and W may be accepted in either order or together; a channel counts
   // as done once it has handshaked in this beat, including this very cycle.
   assign aw_done = aw_acc_q | aw_hs;
   assign w_done  = w_acc_q  | w_hs;

   // ---------------------------------------------------------------------------
   // Next-state / output logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d   = state_q;
      awvalid_d = awvalid_q;
      wvalid_d  = wvalid_q;
      aw_acc_d  = aw_acc_q;
      w_acc_d   = w_acc_q;
      bready_d  = bready_q;
      arvalid_d = arvalid_q;
      rready_d  = rready_q;
      awaddr_d  = awaddr_q;
      araddr_d  = araddr_q;
      wdata_d   = wdata_q;
      rdata_d   = rdata_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start_write_i) begin
               awaddr_d  = addr_i;
               wdata_d   = data_i;
               awvalid_d = 1'b1;
               wvalid_d  = 1'b1;
               aw_acc_d  = 1'b0;
               w_acc_d   = 1'b0;
               state_d   = ST_WR_REQ;
            end else if (start_read_i) begin
               araddr_d  = addr_i;
               arvalid_d = 1'b1;
               state_d   = ST_RD_REQ;
            end
         end

         ST_WR_REQ: begin
            // Each valid drops independently after its own handshake; the
            // start inputs are deliberately not consulted here.
            if (aw_hs) begin
               awvalid_d = 1'b0;
            end
            if (w_hs) begin
               wvalid_d = 1'b0;
            end
            aw_acc_d = aw_done;
            w_acc_d  = w_done;
            if (aw_done && w_done) begin
               aw_acc_d = 1'b0;
               w_acc_d  = 1'b0;
               bready_d = 1'b1;
               state_d  = ST_WR_RESP;
            end
         end

         ST_WR_RESP: begin
            if (b_hs) begin
               bready_d = 1'b0;
               state_d  = ST_DONE;
            end
         end

         ST_RD_REQ: begin
            if (ar_hs) begin
               arvalid_d = 1'b0;
               rready_d  = 1'b1;
               state_d   = ST_RD_RESP;
            end
         end

         ST_RD_RESP: begin
            if (r_hs) begin
               rdata_d  = rdata_i;
               rready_d = 1'b0;
               state_d  = ST_DONE;
            end
         end

         ST_DONE: begin
            // Upstream advances on this edge, so the following IDLE cycle
            // already presents the next beat's operands.
            state_d = ST_IDLE;
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         state_q   <= ST_IDLE;
         awvalid_q <= 1'b0;
         wvalid_q  <= 1'b0;
         aw_acc_q  <= 1'b0;
         w_acc_q   <= 1'b0;
         bready_q  <= 1'b0;
         arvalid_q <= 1'b0;
         rready_q  <= 1'b0;
         awaddr_q  <= '0;
         araddr_q  <= '0;
         wdata_q   <= '0;
         rdata_q   <= '0;
      end else begin
         state_q   <= state_d;
         awvalid_q <= awvalid_d;
         wvalid_q  <= wvalid_d;
         aw_acc_q  <= aw_acc_d;
         w_acc_q   <= w_acc_d;
         bready_q  <= bready_d;
         arvalid_q <= arvalid_d;
         rready_q  <= rready_d;
         awaddr_q  <= awaddr_d;
         araddr_q  <= araddr_d;
         wdata_q   <= wdata_d;
         rdata_q   <= rdata_d;
      end
   end

   // ---------------------------------------------------------------------------
   // Sticky response error
   // ---------------------------------------------------------------------------
`ifdef MAVERIC_AXI_RESP_ERR_EN
   logic error_q, error_d;

   always_comb begin
      error_d = error_q;
      if ((b_hs && resp_is_error(bresp_i)) || (r_hs && resp_is_error(rresp_i))) begin
         error_d = 1'b1;
      end
      // An idle upstream acknowledges the error; this wins over a new set.
      if (!start_read_i && !start_write_i) begin
         error_d = 1'b0;
      end
   end

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         error_q <= 1'b0;
      end else begin
         error_q <= error_d;
      end
   end

   assign error_o = error_q;
`else
   logic unused_resp;
   assign unused_resp = ^{bresp_i, rresp_i};
   assign error_o     = 1'b0;
`endif

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign done_o    = (state_q == ST_DONE);
   assign data_o    = rdata_q;

   assign awaddr_o  = awaddr_q;
   assign awprot_o  = AXI_PROT_DEFAULT;
   assign awvalid_o = awvalid_q;
   assign wdata_o   = wdata_q;
   assign wstrb_o   = '1;
   assign wvalid_o  = wvalid_q;
   assign bready_o  = bready_q;

   assign araddr_o  = araddr_q;
   assign arprot_o  = AXI_PROT_DEFAULT;
   assign arvalid_o = arvalid_q;
   assign rready_o  = rready_q;

endmodule : axi_lite_beat_master
